// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NREQ requesters into a single
// UART transmitter. One byte moves at a time: grant, strobe newd for
// NEWD_CYC cycles, then wait for donetx (bounded by TIMEOUT cycles).
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int NEWD_CYC = 16,
    parameter int TIMEOUT  = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*8-1:0]       data,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [7:0]              dintx,
    output logic                    newd,
    input  logic                    donetx
);

    localparam int GW   = $clog2(NREQ);
    localparam int CMAX = (TIMEOUT > NEWD_CYC) ? TIMEOUT : NEWD_CYC;
    localparam int CW   = $clog2(CMAX) + 1;

    localparam logic [CW-1:0] NEWD_LAST = CW'(NEWD_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]      dintx_q, dintx_d;
    logic            newd_q, newd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;

    logic            grant_vld;
    logic [GW-1:0]   grant_sel;

    // Pick the first requester after the last grant, wrapping around.
    always_comb begin
        logic [GW-1:0] idx;
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_sel = '0;
        idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GW'((int'(ptr_q) + i) % NREQ);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_sel = idx;
            end
        end
    end

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        dintx_d    = dintx_q;
        newd_d     = newd_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d    = LOAD;
                    ptr_d      = grant_sel;
                    grant_id_d = grant_sel;
                    dintx_d    = data[{grant_sel, 3'b000} +: 8];
                    newd_d     = 1'b1;
                    cnt_d      = '0;
                end
            end

            LOAD: begin
                if (cnt_q == NEWD_LAST) begin
                    state_d = WAIT_DONE;
                    newd_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            WAIT_DONE: begin
                // donetx beats a timeout landing on the same edge.
                if (donetx) begin
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                newd_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; ptr resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= GW'(NREQ - 1);
            grant_id_q <= '0;
            dintx_q    <= 8'h00;
            newd_q     <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            dintx_q    <= dintx_d;
            newd_q     <= newd_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_id_q;
    assign dintx    = dintx_q;
    assign newd     = newd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round robin,
// timeout, donetx/timeout race, mid-transfer reset, ignored inputs.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int NEWD_CYC = 16;
    localparam int TIMEOUT  = 100;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ*8-1:0] data;
    logic [NREQ-1:0] ack;
    logic            err;
    logic            busy;
    logic [1:0]      grant_id;
    logic [7:0]      dintx;
    logic            newd;
    logic            donetx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .NEWD_CYC(NEWD_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .err     (err),
        .busy    (busy),
        .grant_id(grant_id),
        .dintx   (dintx),
        .newd    (newd),
        .donetx  (donetx)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        donetx = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Count edges until newd drops (bounded).
    task automatic wait_newd_fall(output int n);
        n = 0;
        while (newd === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req    = 4'b1111;
        donetx = 1'b1;
        data   = 32'hDEAD_BEEF;
        tick();
        n_tests++; if (newd !== 1'b0)     begin n_fail++; $display("FAIL reset_newd got=%b exp=0", newd); end
        n_tests++; if (ack !== 4'b0000)   begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (dintx !== 8'h00)   begin n_fail++; $display("FAIL reset_dintx got=%h exp=00", dintx); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        donetx = 1'b0;
        req    = '0;
        rst    = 1'b0;
    endtask

    task automatic test_single();
        int  n;
        bit  quiet;
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'hA5};
        req  = 4'b0001;
        tick();
        n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        n_tests++; if (newd !== 1'b1)     begin n_fail++; $display("FAIL single_newd got=%b exp=1", newd); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
        n_tests++; if (dintx !== 8'hA5)   begin n_fail++; $display("FAIL single_dintx got=%h exp=a5", dintx); end
        req = '0;  // dropping req after grant must not abort
        wait_newd_fall(n);
        n_tests++; if (n !== NEWD_CYC)    begin n_fail++; $display("FAIL single_newd_len got=%0d exp=%0d", n, NEWD_CYC); end
        quiet = 1'b1;
        repeat (19) begin
            tick();
            if (ack !== 4'b0000 || err !== 1'b0 || busy !== 1'b1 || dintx !== 8'hA5) quiet = 1'b0;
        end
        n_tests++; if (quiet !== 1'b1)    begin n_fail++; $display("FAIL single_wait_quiet got=%b exp=1", quiet); end
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        n_tests++; if (ack !== 4'b0001)   begin n_fail++; $display("FAIL single_ack got=%b exp=0001", ack); end
        n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL single_err got=%b exp=0", err); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL single_idle got=%b exp=0", busy); end
        tick();
        n_tests++; if (ack !== 4'b0000)   begin n_fail++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
    endtask

    task automatic test_round_robin();
        int         n;
        int         gcyc;
        int         exp_id;
        logic [7:0] exp_byte;
        logic [3:0] exp_ack;
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b1111;
        gcyc = 0;
        for (int k = 0; k < 5; k++) begin
            exp_id   = k % 4;
            exp_byte = 8'h11 * 8'(exp_id + 1);
            exp_ack  = 4'b0001 << exp_id;
            tick();
            n_tests++; if (grant_id !== 2'(exp_id)) begin n_fail++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, grant_id, exp_id); end
            n_tests++; if (dintx !== exp_byte)      begin n_fail++; $display("FAIL rr_dintx[%0d] got=%h exp=%h", k, dintx, exp_byte); end
            if (k > 0) begin
                n_tests++; if (cyc - gcyc !== NEWD_CYC + 2) begin n_fail++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", k, cyc - gcyc, NEWD_CYC + 2); end
            end
            gcyc = cyc;
            wait_newd_fall(n);
            donetx = 1'b1;
            tick();
            donetx = 1'b0;
            n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, ack, exp_ack); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bit saw_ack;
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b0100;
        tick();
        n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL tmo_grant got=%0d exp=2", grant_id); end
        req = '0;
        wait_newd_fall(n);
        n       = 0;
        saw_ack = 1'b0;
        while (err !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (ack !== 4'b0000) saw_ack = 1'b1;
        end
        n_tests++; if (n !== TIMEOUT)    begin n_fail++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TIMEOUT); end
        n_tests++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL tmo_no_ack got=%b exp=0", saw_ack); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL tmo_busy got=%b exp=0", busy); end
        tick();
        n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL tmo_err_pulse got=%b exp=0", err); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL tmo_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_coincide();
        int n;
        do_reset();
        req = 4'b0010;
        tick();
        req = '0;
        wait_newd_fall(n);
        repeat (TIMEOUT - 1) tick();
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        n_tests++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL race_ack got=%b exp=0010", ack); end
        n_tests++; if (err !== 1'b0)    begin n_fail++; $display("FAIL race_err got=%b exp=0", err); end
        tick();
        n_tests++; if (err !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL race_after got=err%b/ack%b exp=err0/ack0000", err, ack); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b0010;
        tick();
        repeat (5) tick();
        n_tests++; if (newd !== 1'b1)     begin n_fail++; $display("FAIL rmid_in_load got=%b exp=1", newd); end
        rst = 1'b1;
        req = 4'b1010;
        tick();
        n_tests++; if (newd !== 1'b0)     begin n_fail++; $display("FAIL rmid_newd got=%b exp=0", newd); end
        n_tests++; if (dintx !== 8'h00)   begin n_fail++; $display("FAIL rmid_dintx got=%h exp=00", dintx); end
        n_tests++; if (ack !== 4'b0000)   begin n_fail++; $display("FAIL rmid_ack got=%b exp=0000", ack); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rmid_grant_id got=%0d exp=0", grant_id); end
        tick();
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmid_hold_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick();
        n_tests++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant got=id%0d/busy%b exp=id1/busy1", grant_id, busy); end
        n_tests++; if (dintx !== 8'h22)   begin n_fail++; $display("FAIL rmid_regrant_dintx got=%h exp=22", dintx); end
        n_tests++; if (err !== 1'b0 || ack !== 4'b0000) begin n_fail++; $display("FAIL rmid_no_pulse got=err%b/ack%b exp=err0/ack0000", err, ack); end
        req = '0;
    endtask

    task automatic test_ignore();
        int n;
        bit still;
        do_reset();
        data   = {8'h44, 8'h33, 8'h22, 8'h5A};
        donetx = 1'b1;
        still  = 1'b1;
        repeat (3) begin
            tick();
            if (busy !== 1'b0 || ack !== 4'b0000 || dintx !== 8'h00) still = 1'b0;
        end
        n_tests++; if (still !== 1'b1) begin n_fail++; $display("FAIL ign_idle_donetx got=%b exp=1", still); end
        donetx = 1'b0;
        req    = 4'b0001;
        tick();
        req = '0;
        repeat (4) tick();
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        n_tests++; if (ack !== 4'b0000 || newd !== 1'b1) begin n_fail++; $display("FAIL ign_load_donetx got=ack%b/newd%b exp=ack0000/newd1", ack, newd); end
        wait_newd_fall(n);
        n_tests++; if (n !== NEWD_CYC - 5) begin n_fail++; $display("FAIL ign_newd_len got=%0d exp=%0d", n, NEWD_CYC - 5); end
        data = 32'hFFFF_FFFF;
        repeat (5) tick();
        n_tests++; if (dintx !== 8'h5A)  begin n_fail++; $display("FAIL ign_data_change got=%h exp=5a", dintx); end
        n_tests++; if (busy !== 1'b1 || ack !== 4'b0000) begin n_fail++; $display("FAIL ign_wait_state got=busy%b/ack%b exp=busy1/ack0000", busy, ack); end
        donetx = 1'b1;
        tick();
        donetx = 1'b0;
        n_tests++; if (ack !== 4'b0001)  begin n_fail++; $display("FAIL ign_final_ack got=%b exp=0001", ack); end
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        data   = '0;
        donetx = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
